// File: rtl/fpu_iter_muldiv.sv
// Iterative unsigned integer multiplier (shift-add) / divider (restoring) shared
// as the mantissa engine of the FPU arithmetic sequencer.
//
// state        | meaning
// IDLE         | waiting for start; operands latched on start
// START        | clear accumulator, load iteration counter
// MUL_ADD      | conditionally add multiplicand into high product half
// MUL_SHIFT    | shift {carry, P_hi, A} right, count one iteration
// DIV_SHIFT    | shift {R, Q} left
// DIV_SUB_TEST | trial subtract divisor, set quotient bit
// DIV_CHECK    | count one iteration
// VALID        | result presented until ack
module fpu_iter_muldiv #(
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ack,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] result_hi,
    output logic [WIDTH-1:0] result_lo,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        IDLE, START, MUL_ADD, MUL_SHIFT, DIV_SHIFT, DIV_SUB_TEST, DIV_CHECK, VALID
    } state_t;

    state_t           state, state_nx;
    logic [WIDTH:0]   acc;      // {carry, P_hi} for multiply, R for divide
    logic [WIDTH-1:0] areg;     // A (multiplier) or Q (dividend/quotient)
    logic [WIDTH-1:0] breg;
    logic             op_r;
    logic [CW-1:0]    cnt;
    logic [WIDTH+1:0] diff;
    logic             last;
    logic             b_zero;

    assign diff   = {1'b0, acc} - {2'b00, breg};
    assign last   = (cnt == CW'(1));
    assign b_zero = (breg == '0);

    always_ff @(posedge clk or posedge arst) begin
        if (arst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:         if (start) state_nx = START;
            START:        if (!op_r)      state_nx = MUL_ADD;
                          else if (b_zero) state_nx = VALID;
                          else             state_nx = DIV_SHIFT;
            MUL_ADD:      state_nx = MUL_SHIFT;
            MUL_SHIFT:    state_nx = last ? VALID : MUL_ADD;
            DIV_SHIFT:    state_nx = DIV_SUB_TEST;
            DIV_SUB_TEST: state_nx = DIV_CHECK;
            DIV_CHECK:    state_nx = last ? VALID : DIV_SHIFT;
            VALID:        if (ack) state_nx = IDLE;
            default:      state_nx = IDLE;
        endcase
    end

    // busy/valid decode the state register only, so no input reaches them combinationally
    assign busy  = (state != IDLE);
    assign valid = (state == VALID);

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            acc         <= '0;
            areg        <= '0;
            breg        <= '0;
            op_r        <= 1'b0;
            cnt         <= '0;
            result_hi   <= '0;
            result_lo   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        areg <= a;
                        breg <= b;
                        op_r <= op;
                    end
                end
                START: begin
                    acc         <= '0;
                    cnt         <= CW'(WIDTH);
                    div_by_zero <= op_r && b_zero;
                    if (op_r && b_zero) begin
                        result_lo <= '1;
                        result_hi <= areg;
                    end
                end
                MUL_ADD: begin
                    if (areg[0]) acc <= {1'b0, acc[WIDTH-1:0]} + {1'b0, breg};
                end
                MUL_SHIFT: begin
                    acc  <= {1'b0, acc[WIDTH:1]};
                    areg <= {acc[0], areg[WIDTH-1:1]};
                    cnt  <= cnt - CW'(1);
                    if (last) begin
                        result_hi <= acc[WIDTH:1];
                        result_lo <= {acc[0], areg[WIDTH-1:1]};
                    end
                end
                DIV_SHIFT: begin
                    acc  <= {acc[WIDTH-1:0], areg[WIDTH-1]};
                    areg <= {areg[WIDTH-2:0], 1'b0};
                end
                DIV_SUB_TEST: begin
                    if (!diff[WIDTH+1]) begin
                        acc     <= diff[WIDTH:0];
                        areg[0] <= 1'b1;
                    end
                end
                DIV_CHECK: begin
                    cnt <= cnt - CW'(1);
                    if (last) begin
                        result_hi <= acc[WIDTH-1:0];
                        result_lo <= areg;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fpu_iter_muldiv.sv
// Scoreboard bench for fpu_iter_muldiv at WIDTH 4, 8, 24 and 53: the driver pushes
// expected results and latency, a monitor pops and compares on each valid rise.
module tb_fpu_iter_muldiv;
    typedef struct {
        logic [63:0] hi;
        logic [63:0] lo;
        logic        dbz;
        int          e0;
        int          lat;
    } exp_t;

    localparam int N = 4;
    int wtab [N] = '{4, 8, 24, 53};

    logic        clk = 1'b0;
    logic        arst_s  [N];
    logic        start_s [N];
    logic        op_s    [N];
    logic        ack_s   [N];
    logic [63:0] a_s     [N];
    logic [63:0] b_s     [N];
    wire         busy_s  [N];
    wire         valid_s [N];
    wire         dbz_s   [N];
    wire  [63:0] hi_s    [N];
    wire  [63:0] lo_s    [N];

    exp_t sb [N][$];
    logic vprev [N];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int W = (g == 0) ? 4 : (g == 1) ? 8 : (g == 2) ? 24 : 53;
        logic [W-1:0] h, l;
        fpu_iter_muldiv #(.WIDTH(W)) u_dut (
            .clk(clk), .arst(arst_s[g]), .start(start_s[g]), .op(op_s[g]),
            .a(a_s[g][W-1:0]), .b(b_s[g][W-1:0]), .ack(ack_s[g]),
            .busy(busy_s[g]), .valid(valid_s[g]),
            .result_hi(h), .result_lo(l), .div_by_zero(dbz_s[g])
        );
        assign hi_s[g] = 64'(h);
        assign lo_s[g] = 64'(l);
    end

    task automatic chk(input string nm, input int i, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (W=%0d): got %h expected %h", nm, wtab[i], act, exp);
        end
    endtask

    task automatic mon(input int i);
        exp_t e;
        if (valid_s[i] && !vprev[i]) begin
            if (sb[i].size() == 0) begin
                chk("unexpected_valid", i, 64'd1, 64'd0);
            end else begin
                e = sb[i].pop_front();
                chk("result_hi", i, hi_s[i], e.hi);
                chk("result_lo", i, lo_s[i], e.lo);
                chk("div_by_zero", i, 64'(dbz_s[i]), 64'(e.dbz));
                chk("latency", i, 64'(cyc - e.e0), 64'(e.lat));
            end
        end
        vprev[i] = valid_s[i];
    endtask

    always @(posedge clk) begin
        #1;
        for (int i = 0; i < N; i++) mon(i);
    end

    task automatic issue(input int i, input bit o, input logic [63:0] av, input logic [63:0] bv);
        exp_t        e;
        logic [127:0] p;
        logic [63:0] m;
        int          w, n;
        w = wtab[i];
        m = (64'd1 << w) - 64'd1;
        av = av & m;
        bv = bv & m;
        if (!o) begin
            p     = 128'(av) * 128'(bv);
            e.lo  = p[63:0] & m;
            e.hi  = 64'(p >> w) & m;
            e.dbz = 1'b0;
            e.lat = 2 * w + 1;
        end else if (bv == 64'd0) begin
            e.lo  = m;
            e.hi  = av;
            e.dbz = 1'b1;
            e.lat = 1;
        end else begin
            e.lo  = av / bv;
            e.hi  = av % bv;
            e.dbz = 1'b0;
            e.lat = 3 * w + 1;
        end
        n = 0;
        @(negedge clk);
        while (busy_s[i] && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (busy_s[i]) chk("idle_timeout", i, 64'd1, 64'd0);
        start_s[i] = 1'b1;
        op_s[i]    = o;
        a_s[i]     = av;
        b_s[i]     = bv;
        @(posedge clk);
        #1;
        e.e0 = cyc;
        sb[i].push_back(e);
        @(negedge clk);
        start_s[i] = 1'b0;
        op_s[i]    = ~o;
        a_s[i]     = {$urandom, $urandom};
        b_s[i]     = {$urandom, $urandom};
    endtask

    task automatic wait_valid(input int i, output bit ok);
        int n = 0;
        while (!valid_s[i] && n < 400) begin
            @(negedge clk);
            n++;
        end
        ok = valid_s[i];
        if (!ok) begin
            chk("valid_timeout", i, 64'd0, 64'd1);
            arst_s[i] = 1'b1;
            @(negedge clk);
            arst_s[i] = 1'b0;
            sb[i].delete();
        end
    endtask

    task automatic finish_op(input int i);
        bit ok;
        wait_valid(i, ok);
        if (ok) begin
            ack_s[i] = 1'b1;
            @(negedge clk);
            ack_s[i] = 1'b0;
        end
    endtask

    task automatic run(input int i, input bit o, input logic [63:0] av, input logic [63:0] bv);
        issue(i, o, av, bv);
        finish_op(i);
    endtask

    initial begin
        bit ok;
        for (int i = 0; i < N; i++) begin
            arst_s[i] = 1'b1; start_s[i] = 1'b0; op_s[i] = 1'b0; ack_s[i] = 1'b0;
            a_s[i] = '0; b_s[i] = '0; vprev[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < N; i++) begin
            chk("rst_busy", i, 64'(busy_s[i]), 64'd0);
            chk("rst_valid", i, 64'(valid_s[i]), 64'd0);
            chk("rst_hi", i, hi_s[i], 64'd0);
            chk("rst_lo", i, lo_s[i], 64'd0);
            chk("rst_dbz", i, 64'(dbz_s[i]), 64'd0);
            arst_s[i] = 1'b0;
        end

        run(1, 1'b0, 64'hFF, 64'hFF);
        run(2, 1'b1, 64'h800000, 64'h3);
        run(2, 1'b1, 64'h123456, 64'h0);

        // held result with ignored start pulses, then ack together with start
        issue(1, 1'b0, 64'h0C, 64'h0A);
        wait_valid(1, ok);
        if (ok) begin
            for (int k = 0; k < 20; k++) begin
                start_s[1] = k[0];
                op_s[1] = 1'b1; a_s[1] = 64'hFF; b_s[1] = 64'h01;
                chk("hold_valid", 1, 64'(valid_s[1]), 64'd1);
                chk("hold_result", 1, {hi_s[1][31:0], lo_s[1][31:0]}, 64'h78);
                @(negedge clk);
            end
            start_s[1] = 1'b1;
            ack_s[1] = 1'b1;
            @(posedge clk);
            #1;
            chk("ack_busy", 1, 64'(busy_s[1]), 64'd0);
            chk("ack_valid", 1, 64'(valid_s[1]), 64'd0);
            chk("ack_result_kept", 1, lo_s[1], 64'h78);
            @(negedge clk);
            start_s[1] = 1'b0;
            ack_s[1] = 1'b0;
            @(negedge clk);
            chk("start_not_queued", 1, 64'(busy_s[1]), 64'd0);
        end
        run(1, 1'b1, 64'h64, 64'h07);

        // reset in the middle of a multiply discards it
        issue(2, 1'b0, 64'hABCDEF, 64'h123456);
        repeat (19) @(negedge clk);
        arst_s[2] = 1'b1;
        #1;
        chk("arst_busy", 2, 64'(busy_s[2]), 64'd0);
        chk("arst_valid", 2, 64'(valid_s[2]), 64'd0);
        chk("arst_hi", 2, hi_s[2], 64'd0);
        chk("arst_lo", 2, lo_s[2], 64'd0);
        sb[2].delete();
        @(negedge clk);
        arst_s[2] = 1'b0;
        run(2, 1'b0, 64'h2, 64'h3);

        // boundaries and a small random regression per width
        for (int i = 0; i < N; i++) begin
            run(i, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
            run(i, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1);
            run(i, 1'b1, 64'h3, 64'hFFFF_FFFF_FFFF_FFFF);
            run(i, 1'b0, 64'h0, 64'h5);
            for (int k = 0; k < 30; k++) begin
                run(i, 1'($urandom), {$urandom, $urandom},
                    ($urandom_range(0, 7) == 0) ? 64'd0 : {$urandom, $urandom});
            end
        end

        repeat (3) @(negedge clk);
        for (int i = 0; i < N; i++) chk("scoreboard_empty", i, 64'(sb[i].size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
